// File: rtl/mant_sub_seq_pkg.sv
// Shared definitions for the sequential mantissa subtractor: FSM encoding,
// default slice width and the slice-index width helper.
package mant_sub_seq_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits processed per clock unless overridden
  localparam int SLICE_DEFAULT = 8;

  // Width of the slice index register; never narrower than one bit
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/mant_sub_seq_sub_slice.sv
// One SLICE-bit subtract step: {cout, s} = a + ~b + cin.
// A carry-out of 1 means "no borrow" out of this slice.
module sub_slice
  import mant_sub_seq_pkg::*;
#(
  parameter int SLICE = SLICE_DEFAULT
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_cin,
  output logic [SLICE-1:0] o_s,
  output logic             o_cout
);

  logic [SLICE:0] w_sum;

  assign w_sum  = {1'b0, i_a} + {1'b0, ~i_b} + {{SLICE{1'b0}}, i_cin};
  assign o_s    = w_sum[SLICE-1:0];
  assign o_cout = w_sum[SLICE];

endmodule

// File: rtl/mant_sub_seq.sv
// Multi-cycle unsigned subtractor: diff = a - b, one SLICE-bit slice per
// clock starting at the LSB slice, with the borrow carried in a register
// between slices. A single sub_slice instance is reused for every slice.
module mant_sub_seq
  import mant_sub_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = SLICE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = idx_width(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  // Operand width must split evenly into slices
  if (((WIDTH % SLICE) != 0) || (WIDTH < SLICE)) begin : g_param_err
    $error("mant_sub_seq: WIDTH must be a positive multiple of SLICE");
  end

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_zero;
  logic             r_out_valid;
  logic             r_in_ready;

  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic [SLICE-1:0] w_s;
  logic             w_cout;
  logic [WIDTH-1:0] w_diff_next;

  // Select the operand slices addressed by the current slice index
  always_comb begin
    w_a_slice = {SLICE{1'b0}};
    w_b_slice = {SLICE{1'b0}};
    for (int k = 0; k < NSLICE; k++) begin
      w_a_slice = w_a_slice | ({SLICE{r_idx == IDXW'(k)}} & r_a[k*SLICE +: SLICE]);
      w_b_slice = w_b_slice | ({SLICE{r_idx == IDXW'(k)}} & r_b[k*SLICE +: SLICE]);
    end
  end

  sub_slice #(
    .SLICE (SLICE)
  ) u_sub_slice (
    .i_a    (w_a_slice),
    .i_b    (w_b_slice),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  // Result word with the current slice replaced by this cycle's partial difference
  always_comb begin
    w_diff_next = r_diff;
    for (int k = 0; k < NSLICE; k++) begin
      w_diff_next[k*SLICE +: SLICE] = (r_idx == IDXW'(k)) ? w_s : r_diff[k*SLICE +: SLICE];
    end
  end

  // Control FSM plus operand, carry and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_idx       <= {IDXW{1'b0}};
      r_carry     <= 1'b0;
      r_diff      <= {WIDTH{1'b0}};
      r_borrow    <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_carry    <= 1'b1;   // +1 of the two's complement of b
            r_idx      <= {IDXW{1'b0}};
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_diff  <= w_diff_next;
          r_carry <= w_cout;
          if (r_idx == LAST_IDX) begin
            r_borrow    <= ~w_cout;
            r_zero      <= (w_diff_next == {WIDTH{1'b0}});
            r_out_valid <= 1'b1;
            r_idx       <= {IDXW{1'b0}};
            r_state     <= ST_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        ST_DONE: begin
          // New operands are only taken in the cycle after returning to IDLE
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign zero      = r_zero;

endmodule

// File: tb/tb_mant_sub_seq.sv
// Scoreboard bench for mant_sub_seq (WIDTH=32, SLICE=8): the driver pushes
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_mant_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] diff;
  logic        borrow;
  logic        zero;

  typedef struct {
    logic [31:0] d;
    logic        bw;
    logic        z;
    int          acc;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  exp_t sb_q[$];
  chk_t chk_q[$];

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic rdy_mode = 1'b0;   // 1: random out_ready, 0: out_ready = rdy_force
  logic rdy_force = 1'b1;

  mant_sub_seq #(
    .WIDTH (32),
    .SLICE (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .zero      (zero)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Edge counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer ready: random or forced, changed just after each rising edge
  always @(posedge clk) begin
    #1;
    if (rdy_mode) out_ready = ($urandom_range(0, 2) != 0);
    else          out_ready = rdy_force;
  end

  // Monitor: evaluates posted checks, result handshakes and hold stability
  chk_t        m_c;
  exp_t        m_e;
  logic        prev_valid = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] h_diff = 32'h0;
  logic        h_bw = 1'b0;
  logic        h_z = 1'b0;
  int          valid_cyc = 0;

  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      m_c = chk_q.pop_front();
      total++;
      if (m_c.act !== m_c.exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h", m_c.name, m_c.act, m_c.exp);
      end
    end
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      if (out_valid && !prev_valid) valid_cyc = cyc;
      if (prev_hold) begin
        total++;
        if (!(out_valid === 1'b1 && diff === h_diff && borrow === h_bw &&
              zero === h_z && in_ready === 1'b0)) begin
          bad++;
          $display("FAIL hold: got v=%b d=%h bw=%b z=%b ir=%b expected v=1 d=%h bw=%b z=%b ir=0",
                   out_valid, diff, borrow, zero, in_ready, h_diff, h_bw, h_z);
        end
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got d=%h expected no result", diff);
        end else begin
          m_e = sb_q.pop_front();
          total += 4;
          if (diff !== m_e.d) begin
            bad++;
            $display("FAIL diff: got %h expected %h", diff, m_e.d);
          end
          if (borrow !== m_e.bw) begin
            bad++;
            $display("FAIL borrow: got %b expected %b (diff %h)", borrow, m_e.bw, m_e.d);
          end
          if (zero !== m_e.z) begin
            bad++;
            $display("FAIL zero: got %b expected %b (diff %h)", zero, m_e.z, m_e.d);
          end
          if ((valid_cyc - m_e.acc) != 4) begin
            bad++;
            $display("FAIL latency: got %0d expected 4", valid_cyc - m_e.acc);
          end
        end
      end
      prev_valid = out_valid;
      prev_hold  = out_valid && !out_ready;
      h_diff     = diff;
      h_bw       = borrow;
      h_z        = zero;
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    chk_q.push_back('{name: n, act: act, exp: exp});
  endtask

  // Present one operand pair, wait for acceptance, post the expected result
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] ed, input logic eb, input logic ez);
    int n;
    exp_t e;
    a = ia;
    b = ib;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    e.d = ed; e.bw = eb; e.z = ez; e.acc = cyc;
    sb_q.push_back(e);
    in_valid = 1'b0;
    a = $urandom();
    b = $urandom();
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [31:0] ra, rb;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_diff", diff, 32'd0);
    chk("rst_borrow_zero", {30'd0, borrow, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors
    issue(32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0);
    issue(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b1);
    issue(32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(32'h0000_0001, 32'h8000_0000, 32'h8000_0001, 1'b1, 1'b0);
    wait_valid();
    @(posedge clk);
    #1;

    // Backpressure: hold result for 5 cycles while in_valid pulses
    rdy_force = 1'b0;
    @(posedge clk);
    #1;
    issue(32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = 32'hDEAD_BEEF;
      b = 32'h0000_0001;
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_diff", diff, 32'h0000_0001);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rdy_force = 1'b1;
    @(posedge clk);   // out_ready rises just after this edge
    @(posedge clk);   // handshake edge
    #1;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_diff_kept", diff, 32'h0000_0001);

    // Reset in the middle of RUN, slice index 2
    issue(32'hAAAA_AAAA, 32'h1111_1111, 32'h9999_9999, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_diff", diff, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(32'h1234_5678, 32'h0234_5678, 32'h1000_0000, 1'b0, 1'b0);
    wait_valid();
    @(posedge clk);
    #1;

    // Random pairs with random gaps and consumer stalls
    rdy_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      ra = $urandom();
      rb = (i % 16 == 0) ? ra : $urandom();
      issue(ra, rb, ra - rb, (ra < rb), (ra == rb));
    end
    rdy_mode = 1'b0;
    rdy_force = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("sb_drain", sb_q.size(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
